// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl -- fixed-priority interrupt controller with a register interface
//
// Peripheral interrupt lines are edge-detected and latched into PENDING.
// PENDING & MASK selects the lowest-index source. A three-state handshake
// (IDLE -> REQ -> SERVICE -> IDLE) presents one request at a time to the
// processor.
//
// Parameters
//   NSRC        number of interrupt sources (1..8)
//   VEC_BASE    handler address of source 0
//   VEC_STRIDE  byte spacing between consecutive handler addresses
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   irq         peripheral interrupt lines, a 0->1 edge requests service
//   status_bit  processor interrupt-disable bit (1 = do not issue a request)
//   int_ack     processor acknowledge, honoured only in REQ
//   we          register write strobe
//   addr        byte address, addr[3:2] selects the register:
//                 0 PENDING (R / write-1-to-clear), 1 MASK (RW),
//                 2 STATUS  (R: {27'b0, state, active_id}), 3 EOI (W)
//   wdata       register write data
//   rdata       register read data, combinational from addr
//   interrupt   request to the processor
//   vector      handler address of the granted source
//   active_id   index of the granted source
// ---------------------------------------------------------------------------
module intr_ctrl #(
  parameter int          NSRC       = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq,
  input  logic            status_bit,
  input  logic            int_ack,
  input  logic            we,
  input  logic [3:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            interrupt,
  output logic [31:0]     vector,
  output logic [2:0]      active_id
);

  // Encoding is visible to software through STATUS[4:3].
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [NSRC-1:0] irq_q_reg;
  logic [NSRC-1:0] rise_reg;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] mask_reg;
  logic [2:0]      active_id_reg;
  logic [31:0]     vector_reg;
  logic            interrupt_reg;

  logic            wr_pending;
  logic            wr_mask;
  logic            wr_eoi;
  logic            ack_fire;
  logic [NSRC-1:0] eligible;
  logic            win_valid;
  logic [2:0]      win_id;
  logic [31:0]     win_vector;

  // Address bits below the word select and data bits above the source
  // count carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

  assign wr_pending = we && (addr[3:2] == 2'd0);
  assign wr_mask    = we && (addr[3:2] == 2'd1);
  assign wr_eoi     = we && (addr[3:2] == 2'd3);

  // The ack is honoured in REQ even if the granted source was masked or
  // cleared in the meantime: the grant, once issued, stands.
  assign ack_fire = (state_reg == ST_REQ) && int_ack;

  assign eligible = pending_reg & mask_reg;

  // Fixed priority: scan from the top so the lowest set index is last to
  // write and therefore wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win_id    = 3'(i);
      end
    end
  end

  assign win_vector = VEC_BASE + (32'(win_id) * VEC_STRIDE);

  // Per-bit pending update. A registered rise is OR-ed in after the clears,
  // so an edge arriving in the same cycle as a W1C or the ack-clear of the
  // same bit is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      assign pending_next[gi] = rise_reg[gi] |
                                (pending_reg[gi] &
                                 ~(wr_pending & wdata[gi]) &
                                 ~(ack_fire && (active_id_reg == 3'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      irq_q_reg     <= '0;
      rise_reg      <= '0;
      pending_reg   <= '0;
      mask_reg      <= '0;
      active_id_reg <= 3'd0;
      vector_reg    <= 32'd0;
      interrupt_reg <= 1'b0;
    end else begin
      // irq_q starts at 0 after reset, so a line already high at release
      // is seen as a rising edge.
      irq_q_reg   <= irq;
      rise_reg    <= irq & ~irq_q_reg;
      pending_reg <= pending_next;
      if (wr_mask) begin
        mask_reg <= wdata[NSRC-1:0];
      end

      case (state_reg)
        ST_IDLE: begin
          // status_bit only gates the issue of a new request.
          if (win_valid && !status_bit) begin
            state_reg     <= ST_REQ;
            active_id_reg <= win_id;
            vector_reg    <= win_vector;
            interrupt_reg <= 1'b1;
          end
        end
        ST_REQ: begin
          // Grant is frozen here; later arrivals wait for the next IDLE.
          if (int_ack) begin
            state_reg     <= ST_SERVICE;
            interrupt_reg <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          interrupt_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (addr[3:2])
      2'd0:    rdata = 32'(pending_reg);
      2'd1:    rdata = 32'(mask_reg);
      2'd2:    rdata = {27'd0, state_reg, active_id_reg};
      default: rdata = 32'd0;
    endcase
  end

  assign interrupt = interrupt_reg;
  assign vector    = vector_reg;
  assign active_id = active_id_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl -- self-checking bench for intr_ctrl (NSRC=4, default vectors)
//
// Register-map vectors from a table, hand-written multi-cycle sequences for
// the handshake corner cases, then randomized traffic compared every cycle
// against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

  localparam int NSRC = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NSRC-1:0] irq;
  logic            status_bit;
  logic            int_ack;
  logic            we;
  logic [3:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            interrupt;
  logic [31:0]     vector;
  logic [2:0]      active_id;

  int checks   = 0;
  int failures = 0;

  intr_ctrl #(
    .NSRC      (NSRC),
    .VEC_BASE  (32'h0000_0180),
    .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq       (irq),
    .status_bit(status_bit),
    .int_ack   (int_ack),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .interrupt (interrupt),
    .vector    (vector),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs may be changed on return (1 time unit past the edge).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; addr = 4'h0; wdata = 32'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; irq = '0; status_bit = 1'b0; int_ack = 1'b0;
    we = 1'b0; addr = 4'h0; wdata = 32'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  // state: 0 idle, 1 request outstanding, 2 in service
  int          m_state;
  logic [3:0]  m_prev_irq, m_rise_d, m_pend, m_mask;
  logic [2:0]  m_id;
  logic [31:0] m_vec;
  logic        m_int;

  task automatic model_reset();
    m_state = 0; m_prev_irq = 0; m_rise_d = 0; m_pend = 0; m_mask = 0;
    m_id = 0; m_vec = 0; m_int = 0;
  endtask

  function automatic logic [31:0] model_rdata(input logic [3:0] a);
    case (a >> 2)
      0: return 32'(m_pend);
      1: return 32'(m_mask);
      2: return (32'(m_state) << 3) | 32'(m_id);
      default: return 32'd0;
    endcase
  endfunction

  // Apply one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0] np, elig, low;
    int         word;
    int         nstate;
    word = int'(addr >> 2);
    np = m_pend;
    if (we && word == 0) np = np & ~wdata[3:0];
    if (m_state == 1 && int_ack) np[m_id] = 1'b0;
    np = np | m_rise_d;
    nstate = m_state;
    if (m_state == 0) begin
      elig = m_pend & m_mask;
      if (elig != 0 && !status_bit) begin
        low    = elig & (~elig + 4'd1);        // isolate lowest set bit
        m_id   = 3'($clog2(low));
        m_vec  = 32'h180 + 32'(m_id) * 32'h10;
        m_int  = 1'b1;
        nstate = 1;
      end
    end else if (m_state == 1) begin
      if (int_ack) begin
        m_int  = 1'b0;
        nstate = 2;
      end
    end else begin
      if (we && word == 3) nstate = 0;
    end
    if (we && word == 1) m_mask = wdata[3:0];
    m_state    = nstate;
    m_pend     = np;
    m_rise_d   = irq & ~m_prev_irq;
    m_prev_irq = irq;
  endtask

  // ---------------- register-map table ----------------
  typedef struct {
    string       name;
    logic [3:0]  waddr;
    logic [31:0] wd;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] d;

    tbl[0] = '{"mask_upper_ignored", 4'h4, 32'hFFFF_FFFF, 4'h4, 32'h0000_000F};
    tbl[1] = '{"mask_byte_addr",     4'h5, 32'h0000_0005, 4'h6, 32'h0000_0005};
    tbl[2] = '{"mask_clear",         4'h4, 32'h0000_0000, 4'h4, 32'h0000_0000};
    tbl[3] = '{"status_readonly",    4'h8, 32'hFFFF_FFFF, 4'h8, 32'h0000_0000};
    tbl[4] = '{"pending_w1c_empty",  4'h0, 32'h0000_00FF, 4'h0, 32'h0000_0000};
    tbl[5] = '{"eoi_idle_ignored",   4'hC, 32'h1234_5678, 4'h8, 32'h0000_0000};
    tbl[6] = '{"mask_pattern",       4'h4, 32'h0000_000A, 4'h7, 32'h0000_000A};
    tbl[7] = '{"eoi_reads_zero",     4'h4, 32'h0000_0003, 4'hC, 32'h0000_0000};

    do_reset();
    chk("reset_interrupt", interrupt, 0);
    chk("reset_vector",    vector,    0);
    chk("reset_active_id", active_id, 0);
    chk_reg("reset_pending", 4'h0, 0);
    chk_reg("reset_status",  4'h8, 0);

    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].waddr, tbl[i].wd);
      chk_reg(tbl[i].name, tbl[i].raddr, tbl[i].exp);
    end

    // ---- single source: 3-cycle latency, ack, SERVICE ----
    do_reset();
    wr(4'h4, 32'h1);
    irq = 4'b0001;                       // cycle 0
    tick(); chk("lat_c1", interrupt, 0);
    tick(); chk("lat_c2", interrupt, 0);
    tick(); chk("lat_c3", interrupt, 1); // cycle 3
    chk("single_vector", vector, 32'h180);
    chk("single_id", active_id, 0);
    tick(); chk("hold_c4", interrupt, 1);
    tick(); chk("hold_c5", interrupt, 1);
    int_ack = 1'b1;                      // ack in cycle 5
    tick(); int_ack = 1'b0;              // cycle 6
    chk("ack_deassert", interrupt, 0);
    chk_reg("ack_pending_clr", 4'h0, 0);
    chk_reg("status_service", 4'h8, 32'h10);

    // ---- hold in SERVICE, then EOI with one idle cycle ----
    irq = 4'b0000; tick();
    irq = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("service_hold", interrupt, 0);
    end
    chk_reg("service_accum", 4'h0, 32'h1);
    wr(4'hC, 32'h0);
    chk("eoi_idle_gap", interrupt, 0);
    chk_reg("eoi_status_idle", 4'h8, 32'h0);
    tick();
    chk("eoi_regrant", interrupt, 1);

    // ---- stray EOI and ack in IDLE ----
    do_reset();
    wr(4'hC, 32'h0);
    int_ack = 1'b1; tick(); tick(); int_ack = 1'b0;
    chk_reg("stray_status", 4'h8, 0);
    chk("stray_interrupt", interrupt, 0);

    // ---- priority ----
    do_reset();
    wr(4'h4, 32'hF);
    irq = 4'b0110;
    tick(); tick(); tick();
    chk("prio_int", interrupt, 1);
    chk("prio_id", active_id, 1);
    chk("prio_vector", vector, 32'h190);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk_reg("prio_status", 4'h8, 32'h11);
    wr(4'hC, 32'h0);
    chk("prio_gap", interrupt, 0);
    tick();
    chk("prio2_int", interrupt, 1);
    chk("prio2_id", active_id, 2);
    chk("prio2_vector", vector, 32'h1A0);

    // ---- masked, then disabled by status_bit ----
    do_reset();
    irq = 4'b1000;
    tick(); tick(); tick(); tick();
    chk_reg("masked_pending", 4'h0, 32'h8);
    chk("masked_noint", interrupt, 0);
    status_bit = 1'b1;
    wr(4'h4, 32'h8);
    tick(); tick();
    chk("disabled_noint", interrupt, 0);
    status_bit = 1'b0;
    tick();
    chk("enabled_int", interrupt, 1);
    chk("enabled_vector", vector, 32'h1B0);
    status_bit = 1'b1;
    tick();
    chk("status_no_withdraw", interrupt, 1);
    status_bit = 1'b0;

    // ---- W1C racing a pending set ----
    do_reset();
    irq = 4'b0010;
    tick();
    we = 1'b1; addr = 4'h0; wdata = 32'h2;
    tick();
    we = 1'b0; wdata = 32'h0;
    chk_reg("w1c_race", 4'h0, 32'h2);
    wr(4'h0, 32'h2);
    chk_reg("w1c_normal", 4'h0, 32'h0);

    // ---- asynchronous reset while requesting ----
    do_reset();
    wr(4'h4, 32'h1);
    irq = 4'b0001;
    tick(); tick(); tick();
    chk("pre_reset_int", interrupt, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_int", interrupt, 0);
    chk("async_vector", vector, 0);
    chk("async_id", active_id, 0);
    chk_reg("async_pending", 4'h0, 0);
    chk_reg("async_mask", 4'h4, 0);
    tick();
    reset_n = 1'b1;
    chk_reg("release_idle", 4'h8, 0);
    tick(); tick();
    chk_reg("release_rise", 4'h0, 32'h1);

    // ---- randomized traffic vs. model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      status_bit = ($urandom_range(0, 3) == 0);
      int_ack    = ($urandom_range(0, 2) == 0);
      we         = ($urandom_range(0, 3) == 0);
      addr       = 4'($urandom_range(0, 15));
      wdata      = $urandom;
      #1;
      chk("rand_interrupt", interrupt, m_int);
      chk("rand_vector", vector, m_vec);
      chk("rand_active_id", active_id, m_id);
      chk("rand_rdata", rdata, model_rdata(addr));
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter: NSRC, default 4, number of interrupt sources (1..8).
REQ-002 Parameter: VEC_BASE, default 32'h0000_0180, vector address of source 0.
REQ-003 Parameter: VEC_STRIDE, default 32'h10, byte spacing between consecutive source vectors.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 irq  in  NSRC  peripheral interrupt lines; a source requests on a 0->1 edge.
REQ-007 status_bit  in  1  processor interrupt-disable bit; 1 = processor will not accept.
REQ-008 int_ack  in  1  processor acknowledge; qualified only while interrupt=1.
REQ-009 we  in  1  register-write strobe from the data bus.
REQ-010 addr  in  4  byte address; addr[3:2] selects the register.
REQ-011 wdata  in  32  register write data.
REQ-012 rdata  out  32  register read data, combinational from addr.
REQ-013 interrupt  out  1  request to the processor.
REQ-014 vector  out  32  handler address of the granted source; valid while interrupt=1 or in SERVICE.
REQ-015 active_id  out  3  granted source index.

Function
REQ-016 Edge detect: irq shall be registered once (irq_q); rise = irq & ~irq_q sets pending[i] in the following cycle.
REQ-017 Register map: 0 PENDING (R, write-1-to-clear); 1 MASK (RW, bit=1 enables); 2 STATUS (R: {27'b0, state[1:0], active_id}); 3 EOI (W, any value). Bits at or above NSRC shall read 0 and ignore writes.
REQ-018 A simultaneous rise and W1C on the same pending bit shall leave the bit set.
REQ-019 eligible = pending & MASK; priority is fixed, with the lowest index winning.
REQ-020 The FSM shall have exactly three states: IDLE, REQ, and SERVICE.
REQ-021 IDLE->REQ: when eligible!=0 and status_bit=0, register active_id=winner and vector=VEC_BASE+winner*VEC_STRIDE (32-bit, wrap ignored), and assert interrupt in the next cycle.
REQ-022 REQ: interrupt, vector, and active_id shall hold stable; a later higher-priority arrival shall not change the grant.
REQ-023 REQ->SERVICE: on int_ack=1, deassert interrupt next cycle and clear pending[active_id] in the same edge.
REQ-024 REQ with the granted source masked or W1C-cleared before ack: the grant stands; the ack shall still be honoured.
REQ-025 SERVICE: no new request shall be issued; pending bits continue to accumulate.
REQ-026 SERVICE->IDLE: on a write to EOI. A new grant is possible no earlier than the cycle after returning to IDLE, giving a minimum of one idle cycle between requests.
REQ-027 EOI writes in IDLE or REQ, and int_ack outside REQ, shall be ignored.
REQ-028 status_bit=1 shall only block the IDLE->REQ transition; it shall not withdraw an asserted interrupt.
REQ-029 Latency from a rising edge of irq to interrupt=1 shall be 3 cycles (detect, pending, grant) when IDLE, unmasked, and status_bit=0.

Reset
REQ-030 reset_n=0 shall immediately clear pending, MASK, irq_q, active_id, vector, and interrupt, and force state=IDLE, regardless of clock.
REQ-031 Reset asserted in REQ or SERVICE shall abort the transaction; no pending bit shall survive.
REQ-032 Any irq line already high at reset release shall be treated as having risen (irq_q=0) and shall become pending.

Verification
REQ-033 Single source: MASK=4'b0001, irq[0] rises at cycle 0 -> interrupt=1 at cycle 3, vector=32'h180; ack at cycle 5 -> interrupt=0 at cycle 6, PENDING=0, STATUS state=SERVICE.
REQ-034 Priority: irq[2] and irq[1] rise together with MASK=4'hF -> grant active_id=1, vector=32'h190; after EOI -> second grant active_id=2, vector=32'h1A0.
REQ-035 Masked and disabled: irq[3] rises with MASK=0 -> PENDING=4'b1000, no interrupt; write MASK=4'h8 with status_bit=1 -> still no interrupt; drop status_bit -> interrupt=1, vector=32'h1B0.
REQ-036 Hold and stray: irq[0] pending in SERVICE with no EOI -> interrupt stays 0 for 20 cycles; an EOI write in IDLE and int_ack pulses in IDLE -> no state change.
REQ-037 W1C race: W1C of bit 1 in the same cycle as irq[1]'s pending set -> PENDING[1]=1.
REQ-038 Reset mid-REQ: assert reset_n=0 asynchronously while interrupt=1 -> interrupt=0 and all registers 0 before the next clock edge; after release -> IDLE.
